// File: rtl/apb_spi_accel_sampler.sv
// apb_spi_accel_sampler
//   APB3 slave that burst-reads NUM_CH channels from an SPI (mode 0)
//   accelerometer, either periodically or on a one-shot request. Each burst
//   is one frame. Frames are queued in an RX FIFO that the CPU drains
//   through the DATA_i registers.
//
//   Ports
//     pclk_i, presetn_i      clock, asynchronous active-low reset
//     paddr_i .. pstrb_i     APB3 request (zero wait states)
//     pready_o, prdata_o,    APB3 response
//     pslverr_o
//     irq_o                  IRQEN & (LEVEL >= THR | OVF)
//     ACL_MISO/MOSI/SCLK/CSN SPI master pins, SCLK idles low, CSN active low
//
//   Register map (byte offsets)
//     00 CTRL    [0]EN [1]ONESHOT(W1) [2]FIFO_CLR(W1) [3]IRQEN [12:8]THR
//     04 STATUS  [0]BUSY [1]EMPTY [2]FULL [3]OVF(W1C) [13:8]LEVEL
//     08 CLKDIV  [7:0] SCLK half period = CLKDIV+1 cycles
//     0C PERIOD  trigger period in pclk cycles, 0 disables periodic mode
//     10+4*i     DATA_i, head frame channel i (reading the last one pops)
module apb_spi_accel_sampler #(
    parameter int         NUM_CH     = 3,
    parameter int         DATA_W     = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] START_ADDR = 8'h0E,
    parameter int         PERIOD_W   = 24
) (
    input  logic        pclk_i,
    input  logic        presetn_i,
    input  logic [31:0] paddr_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    input  logic [3:0]  pstrb_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    output logic        irq_o,
    input  logic        ACL_MISO,
    output logic        ACL_MOSI,
    output logic        ACL_SCLK,
    output logic        ACL_CSN
);

    localparam int FRAME_W = NUM_CH * DATA_W;
    localparam int NBITS   = 8 * (2 + FRAME_W / 8);
    localparam int BW      = $clog2(NBITS);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP
    } state_t;

    // Channel i of a frame: bytes arrive little-endian, result sign-extended.
    function automatic logic [31:0] chan_word(input logic [FRAME_W-1:0] f, input int idx);
        logic [DATA_W-1:0] raw;
        raw = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            raw[8*b +: 8] = f[FRAME_W - 1 - 8 * (idx * (DATA_W / 8) + b) -: 8];
        end
        return {{(32 - DATA_W){raw[DATA_W-1]}}, raw};
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    // Register state
    logic                en_q, irqen_q, ovf_q;
    logic [4:0]          thr_q;
    logic [7:0]          clkdiv_q;
    logic [PERIOD_W-1:0] period_q, per_cnt_q;

    // Transfer engine state
    state_t              state_q, state_nxt;
    logic [7:0]          hcnt_q, div_lat_q;
    logic [BW-1:0]       bit_cnt_q;
    logic                sclk_q, sclk_nxt, csn_q, csn_nxt;
    logic                gap_half_q, gap_half_nxt;
    logic                pending_q;
    logic [15:0]         tx_q;
    logic [FRAME_W-1:0]  rx_q;
    logic                load_frame, sample, shift_tx, bit_inc, push_req, half_tick;

    // FIFO
    logic [FRAME_W-1:0]  mem [FIFO_DEPTH];
    logic [LW-1:0]       wr_ptr_q, rd_ptr_q, level;
    logic                full, empty, do_push, do_pop;

    // APB decode
    logic                access, rd_acc, wr_acc, err;
    logic [5:0]          word, data_idx;
    logic                is_ctrl, is_stat, is_div, is_per, is_data;
    logic                ctrl_we, stat_we, div_we, per_we;
    logic                oneshot_w, clr_w, ovf_clr, pop_req;
    logic                cnt_on, per_hit, trig, busy;
    logic                unused_addr;

    assign unused_addr = ^paddr_i[31:8];

    assign access   = psel_i & penable_i;
    assign pready_o = access;
    assign rd_acc   = access & ~pwrite_i;
    assign wr_acc   = access & pwrite_i;

    assign word     = paddr_i[7:2];
    assign data_idx = word - 6'd4;
    assign is_ctrl  = (word == 6'd0);
    assign is_stat  = (word == 6'd1);
    assign is_div   = (word == 6'd2);
    assign is_per   = (word == 6'd3);
    assign is_data  = (word >= 6'd4) && (word < 6'(4 + NUM_CH));

    // STATUS only accepts a write that touches nothing but the OVF bit.
    assign err = (paddr_i[1:0] != 2'b00)
               || !(is_ctrl || is_stat || is_div || is_per || is_data)
               || (pwrite_i && is_stat && ((pwdata_i & ~32'h8) != 32'h0))
               || (pwrite_i && is_data);

    assign pslverr_o = access & err;

    assign ctrl_we   = wr_acc & ~err & is_ctrl;
    assign stat_we   = wr_acc & ~err & is_stat;
    assign div_we    = wr_acc & ~err & is_div;
    assign per_we    = wr_acc & ~err & is_per;
    assign oneshot_w = ctrl_we & pstrb_i[0] & pwdata_i[1];
    assign clr_w     = ctrl_we & pstrb_i[0] & pwdata_i[2];
    assign ovf_clr   = stat_we & pstrb_i[0] & pwdata_i[3];
    assign pop_req   = rd_acc & ~err & is_data & (data_idx == 6'(NUM_CH - 1));

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == LW'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign busy  = (state_q != S_IDLE);

    // A FIFO clear overrides both a push and a pop in the same cycle.
    assign do_push = push_req & ~full & ~clr_w;
    assign do_pop  = pop_req & ~empty & ~clr_w;

    assign irq_o = irqen_q & ((6'(level) >= 6'(thr_q)) | ovf_q);

    always_comb begin
        prdata_o = '0;
        if (rd_acc && !err) begin
            if (is_ctrl)      prdata_o = {19'b0, thr_q, 4'b0, irqen_q, 2'b0, en_q};
            else if (is_stat) prdata_o = {18'b0, 6'(level), 4'b0, ovf_q, full, empty, busy};
            else if (is_div)  prdata_o = {24'b0, clkdiv_q};
            else if (is_per)  prdata_o = 32'(period_q);
            else if (!empty)  prdata_o = chan_word(mem[rd_ptr_q[AW-1:0]], int'(data_idx));
        end
    end

    // Period counter: wraps and fires on PERIOD-1, so triggers are PERIOD apart.
    assign cnt_on  = en_q && (period_q != '0);
    assign per_hit = cnt_on && (per_cnt_q >= period_q - PERIOD_W'(1));
    assign trig    = per_hit | oneshot_w;

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            en_q      <= 1'b0;
            irqen_q   <= 1'b0;
            thr_q     <= '0;
            clkdiv_q  <= 8'd4;
            period_q  <= '0;
            per_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (ctrl_we && pstrb_i[0]) begin
                en_q    <= pwdata_i[0];
                irqen_q <= pwdata_i[3];
            end
            if (ctrl_we && pstrb_i[1]) thr_q <= pwdata_i[12:8];
            if (div_we && pstrb_i[0])  clkdiv_q <= pwdata_i[7:0];
            if (per_we) period_q <= PERIOD_W'(merge_bytes(32'(period_q), pwdata_i, pstrb_i));

            if (!cnt_on || per_hit) per_cnt_q <= '0;
            else                    per_cnt_q <= per_cnt_q + PERIOD_W'(1);

            if (push_req && full && !clr_w) ovf_q <= 1'b1;
            else if (ovf_clr)               ovf_q <= 1'b0;
        end
    end

    // Every non-idle state advances on half-period boundaries.
    assign half_tick = (hcnt_q == div_lat_q);

    always_comb begin
        state_nxt    = state_q;
        sclk_nxt     = sclk_q;
        csn_nxt      = csn_q;
        gap_half_nxt = gap_half_q;
        load_frame   = 1'b0;
        sample       = 1'b0;
        shift_tx     = 1'b0;
        bit_inc      = 1'b0;
        push_req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig || pending_q) begin
                    state_nxt  = S_CS_SETUP;
                    csn_nxt    = 1'b0;
                    load_frame = 1'b1;
                end
            end
            S_CS_SETUP: begin
                if (half_tick) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (half_tick) begin
                    if (!sclk_q) begin
                        sclk_nxt = 1'b1;
                        sample   = 1'b1;
                    end else begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt_q == BW'(NBITS - 1)) begin
                            state_nxt = S_CS_HOLD;
                        end else begin
                            bit_inc  = 1'b1;
                            shift_tx = 1'b1;
                        end
                    end
                end
            end
            S_CS_HOLD: begin
                if (half_tick) begin
                    state_nxt    = S_GAP;
                    csn_nxt      = 1'b1;
                    push_req     = 1'b1;
                    gap_half_nxt = 1'b0;
                end
            end
            S_GAP: begin
                if (half_tick) begin
                    if (!gap_half_q) begin
                        gap_half_nxt = 1'b1;
                    end else if (pending_q) begin
                        state_nxt  = S_CS_SETUP;
                        csn_nxt    = 1'b0;
                        load_frame = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q    <= S_IDLE;
            hcnt_q     <= '0;
            div_lat_q  <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            csn_q      <= 1'b1;
            gap_half_q <= 1'b0;
            pending_q  <= 1'b0;
            tx_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_nxt;
            sclk_q     <= sclk_nxt;
            csn_q      <= csn_nxt;
            gap_half_q <= gap_half_nxt;

            if (state_q == S_IDLE || load_frame || half_tick) hcnt_q <= '0;
            else                                              hcnt_q <= hcnt_q + 8'd1;

            // CLKDIV is latched per frame so a mid-transfer write waits.
            if (load_frame) div_lat_q <= clkdiv_q;

            if (load_frame)   bit_cnt_q <= '0;
            else if (bit_inc) bit_cnt_q <= bit_cnt_q + BW'(1);

            if (load_frame)    tx_q <= {8'h0B, START_ADDR};
            else if (shift_tx) tx_q <= {tx_q[14:0], 1'b0};

            // One trigger can be remembered while busy; extras are dropped.
            if (load_frame)             pending_q <= trig && (state_q != S_IDLE);
            else if (trig && busy)      pending_q <= 1'b1;

            if (clr_w) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + LW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + LW'(1);
            end
        end
    end

    // Command bits shift through the top of rx_q and fall off the end.
    always_ff @(posedge pclk_i) begin
        if (sample) rx_q <= {rx_q[FRAME_W-2:0], ACL_MISO};
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= rx_q;
    end

    assign ACL_MOSI = tx_q[15];
    assign ACL_SCLK = sclk_q;
    assign ACL_CSN  = csn_q;

endmodule

// File: tb/tb_apb_spi_accel_sampler.sv
module tb_apb_spi_accel_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = 4'hF;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        irq;
    logic        miso = 1'b0;
    logic        mosi, sclk, csn;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          fall_cnt = 0;
    int          fall_cyc [0:63];
    int          bidx = 0;
    int          mbit = 0;
    logic        prev_csn = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [15:0] mosi_cmd = '0;
    logic [7:0]  resp [0:5];
    logic        rdy_seen = 1'b0;

    apb_spi_accel_sampler dut (
        .pclk_i   (clk),
        .presetn_i(rst_n),
        .paddr_i  (paddr),
        .psel_i   (psel),
        .penable_i(penable),
        .pwrite_i (pwrite),
        .pwdata_i (pwdata),
        .pstrb_i  (pstrb),
        .pready_o (pready),
        .prdata_o (prdata),
        .pslverr_o(pslverr),
        .irq_o    (irq),
        .ACL_MISO (miso),
        .ACL_MOSI (mosi),
        .ACL_SCLK (sclk),
        .ACL_CSN  (csn)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cyc <= cyc + 1;

    function automatic logic resp_bit(input int k);
        if (k < 16 || k >= 64) return 1'b0;
        return resp[(k - 16) / 8][7 - ((k - 16) % 8)];
    endfunction

    // Sensor model: drives MISO on SCLK falling edges, records MOSI command bits.
    always @(csn or sclk) begin
        if (prev_csn === 1'b1 && csn === 1'b0) begin
            if (fall_cnt < 64) fall_cyc[fall_cnt] = cyc;
            fall_cnt = fall_cnt + 1;
            bidx = 0;
            mbit = 0;
            miso = resp_bit(0);
        end else if (csn === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0) begin
            bidx = bidx + 1;
            miso = resp_bit(bidx);
        end else if (csn === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) begin
            if (mbit < 16) mosi_cmd[15 - mbit] = mosi;
            mbit = mbit + 1;
        end
        prev_csn  = csn;
        prev_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        d = prdata;
        e = pslverr;
        rdy_seen = pready;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                          output logic e);
        @(negedge clk);
        paddr = a; pwrite = 1'b1; pwdata = dat; pstrb = s; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        e = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wait_level(input int n, input string tag);
        logic [31:0] d;
        logic        e;
        d = '0;
        for (int i = 0; i < 1000; i++) begin
            apb_rd(32'h04, d, e);
            if (int'(d[13:8]) == n) break;
        end
        check(tag, 32'(d[13:8]), 32'(n));
    endtask

    task automatic wait_csn_low(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (csn === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          f0;

        resp[0] = 8'h34; resp[1] = 8'h12; resp[2] = 8'hFF;
        resp[3] = 8'h80; resp[4] = 8'h00; resp[5] = 8'h00;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csn", 32'(csn), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        apb_rd(32'h04, d, e); check("rst_status", d, 32'h2); check("rst_status_err", 32'(e), 32'd0);
        check("pready", 32'(rdy_seen), 32'd1);
        apb_rd(32'h08, d, e); check("rst_clkdiv", d, 32'h4);
        apb_rd(32'h00, d, e); check("rst_ctrl", d, 32'h0);
        apb_rd(32'h0C, d, e); check("rst_period", d, 32'h0);
        apb_rd(32'h10, d, e); check("rst_data0_empty", d, 32'h0);

        // One-shot frame
        apb_wr(32'h08, 32'h1, 4'hF, e);
        apb_rd(32'h08, d, e); check("clkdiv_rb", d, 32'h1);
        apb_wr(32'h00, 32'h2, 4'hF, e);
        wait_level(1, "os_level");
        check("os_mosi_cmd", 32'(mosi_cmd), 32'h0B0E);
        apb_rd(32'h10, d, e); check("os_data0", d, 32'h0000_1234);
        apb_rd(32'h14, d, e); check("os_data1", d, 32'hFFFF_80FF);
        apb_rd(32'h18, d, e); check("os_data2", d, 32'h0);
        apb_rd(32'h04, d, e); check("os_status_empty", d, 32'h2);
        apb_rd(32'h00, d, e); check("os_ctrl_selfclr", d, 32'h0);

        // Error responses leave state untouched
        apb_rd(32'h02, d, e); check("err_rd02_flag", 32'(e), 32'd1); check("err_rd02_data", d, 32'h0);
        apb_rd(32'h40, d, e); check("err_rd40_flag", 32'(e), 32'd1); check("err_rd40_data", d, 32'h0);
        apb_wr(32'h10, 32'h5, 4'hF, e); check("err_wr10_flag", 32'(e), 32'd1);
        apb_wr(32'h04, 32'h2, 4'hF, e); check("err_wr04_flag", 32'(e), 32'd1);
        apb_wr(32'h01, 32'hFFFF_FFFF, 4'hF, e); check("err_wr01_flag", 32'(e), 32'd1);
        apb_rd(32'h00, d, e); check("err_ctrl_kept", d, 32'h0);
        apb_rd(32'h04, d, e); check("err_status_kept", d, 32'h2);

        // Pop of DATA2 in the push cycle keeps LEVEL (push lands 260 cycles after CSN falls)
        apb_wr(32'h00, 32'h2, 4'hF, e);
        wait_level(1, "sim_pop_pre_level");
        resp[0] = 8'h01; resp[1] = 8'h00; resp[2] = 8'h02;
        resp[3] = 8'h00; resp[4] = 8'h03; resp[5] = 8'h00;
        apb_wr(32'h00, 32'h2, 4'hF, e);
        wait_csn_low("sim_pop_csn");
        repeat (257) @(negedge clk);
        apb_rd(32'h18, d, e); check("sim_pop_old_data2", d, 32'h0);
        repeat (10) @(negedge clk);
        apb_rd(32'h04, d, e); check("sim_pop_status", d, 32'h100);
        apb_rd(32'h10, d, e); check("sim_pop_new_data0", d, 32'h1);
        apb_rd(32'h18, d, e); check("sim_pop_new_data2", d, 32'h3);
        apb_rd(32'h04, d, e); check("sim_pop_drained", d, 32'h2);

        // FIFO_CLR in the push cycle wins
        apb_wr(32'h00, 32'h2, 4'hF, e);
        wait_csn_low("clr_csn");
        repeat (257) @(negedge clk);
        apb_wr(32'h00, 32'h4, 4'h1, e);
        repeat (10) @(negedge clk);
        apb_rd(32'h04, d, e); check("clr_push_status", d, 32'h2);

        // ONESHOT while busy: exactly one extra frame
        f0 = fall_cnt;
        apb_wr(32'h00, 32'h2, 4'hF, e);
        wait_csn_low("busy_os_csn");
        apb_wr(32'h00, 32'h2, 4'hF, e);
        apb_wr(32'h00, 32'h2, 4'hF, e);
        repeat (1500) @(negedge clk);
        check("busy_os_frames", 32'(fall_cnt - f0), 32'd2);
        apb_rd(32'h04, d, e); check("busy_os_status", d, 32'h200);
        apb_wr(32'h00, 32'h4, 4'hF, e);
        apb_rd(32'h04, d, e); check("busy_os_cleared", d, 32'h2);

        // Periodic triggering, overflow and W1C
        apb_wr(32'h08, 32'h4, 4'hF, e);
        apb_wr(32'h0C, 32'd1000, 4'hF, e);
        apb_rd(32'h0C, d, e); check("period_rb", d, 32'd1000);
        f0 = fall_cnt;
        apb_wr(32'h00, 32'h1, 4'hF, e);
        for (int i = 0; i < 12000 && fall_cnt < f0 + 9; i++) @(negedge clk);
        check("per_nine_frames", 32'(fall_cnt - f0 >= 9), 32'd1);
        repeat (700) @(negedge clk);
        check("per_interval_first", 32'(fall_cyc[f0 + 1] - fall_cyc[f0]), 32'd1000);
        check("per_interval_last", 32'(fall_cyc[f0 + 8] - fall_cyc[f0 + 7]), 32'd1000);
        apb_rd(32'h04, d, e); check("per_full_ovf", d, 32'h80C);
        apb_wr(32'h00, 32'h0, 4'hF, e);
        apb_wr(32'h04, 32'h8, 4'hF, e); check("w1c_err", 32'(e), 32'd0);
        apb_rd(32'h04, d, e); check("w1c_status", d, 32'h804);
        apb_wr(32'h0C, 32'h0, 4'hF, e);
        apb_wr(32'h00, 32'h4, 4'hF, e);
        apb_rd(32'h04, d, e); check("per_cleared", d, 32'h2);

        // IRQ threshold
        apb_wr(32'h00, 32'h0208, 4'hF, e);
        apb_rd(32'h00, d, e); check("irq_ctrl_rb", d, 32'h208);
        check("irq_idle", 32'(irq), 32'd0);
        apb_wr(32'h00, 32'h020A, 4'hF, e);
        wait_level(1, "irq_level1");
        check("irq_one_frame", 32'(irq), 32'd0);
        apb_wr(32'h00, 32'h020A, 4'hF, e);
        wait_level(2, "irq_level2");
        check("irq_two_frames", 32'(irq), 32'd1);
        apb_rd(32'h18, d, e);
        @(negedge clk);
        check("irq_after_pop", 32'(irq), 32'd0);

        // Reset in the middle of SHIFT
        apb_wr(32'h00, 32'h2, 4'hF, e);
        wait_csn_low("rst_mid_csn_low");
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_csn", 32'(csn), 32'd1);
        check("rst_mid_sclk", 32'(sclk), 32'd0);
        check("rst_mid_mosi", 32'(mosi), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apb_rd(32'h04, d, e); check("rst_mid_status", d, 32'h2);
        apb_rd(32'h08, d, e); check("rst_mid_clkdiv", d, 32'h4);
        repeat (800) @(negedge clk);
        apb_rd(32'h04, d, e); check("rst_mid_no_frame", d, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
